// File: rtl/eth_rx_hdr_filter_if.sv
// Byte-wide AXI-stream bundle (no tready) for the receive path.
// The master modport drives the bundle; the slave modport samples it.
interface eth_rx_hdr_filter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, tvalid, tlast, tuser);
  modport slave  (input  tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/eth_rx_hdr_filter.sv
// Strips the Ethernet header, filters on destination MAC, forwards the payload one cycle later.
// Latency is one cycle for header, payload and stats; there is no backpressure, and invalid cycles hold all state.
module eth_rx_hdr_filter #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  eth_rx_hdr_filter_if.slave     s_axis,
  eth_rx_hdr_filter_if.master    m_axis,
  output logic                   hdr_valid,
  output logic [47:0]            hdr_dest_mac,
  output logic [47:0]            hdr_src_mac,
  output logic [15:0]            hdr_type,
  input  logic [47:0]            cfg_local_mac,
  input  logic                   cfg_promisc,
  input  logic                   cfg_bcast_enable,
  input  logic                   cfg_mcast_enable,
  output logic                   stat_rx_frame,
  output logic                   stat_rx_drop,
  output logic                   stat_rx_trunc,
  output logic                   stat_rx_error,
  output logic [COUNT_WIDTH-1:0] count_rx_frame,
  output logic [COUNT_WIDTH-1:0] count_rx_drop
);

  if (DATA_WIDTH != 8) begin : g_width_check
    $fatal(1, "eth_rx_hdr_filter: DATA_WIDTH must be 8");
  end

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DROP} state_t;

  typedef struct packed {
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] etype;
  } hdr_t;

  state_t       state, state_nxt;
  logic [3:0]   byte_cnt, byte_cnt_nxt;
  logic [103:0] shadow;
  hdr_t         hdr_w, hdr_q;
  logic         match;
  logic         shift_en, hdr_evt, drop_evt, trunc_evt, beat_evt;

  logic [7:0]   m_tdata_q;
  logic         m_tvalid_q, m_tlast_q, m_tuser_q;

  // The 14th byte completes the header in the same cycle it arrives, so the
  // filter looks at the shadow bytes concatenated with the live input byte.
  assign hdr_w = {shadow, s_axis.tdata};
  assign match = cfg_promisc
               | (hdr_w.dest == cfg_local_mac)
               | (cfg_bcast_enable & (&hdr_w.dest))
               | (cfg_mcast_enable & hdr_w.dest[40]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      byte_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    shift_en     = 1'b0;
    hdr_evt      = 1'b0;
    drop_evt     = 1'b0;
    trunc_evt    = 1'b0;
    beat_evt     = 1'b0;
    if (s_axis.tvalid) begin
      case (state)
        IDLE: begin
          shift_en = 1'b1;
          if (s_axis.tlast) begin
            trunc_evt = 1'b1;
          end else begin
            state_nxt    = HEADER;
            byte_cnt_nxt = 4'd1;
          end
        end
        HEADER: begin
          shift_en     = 1'b1;
          byte_cnt_nxt = byte_cnt + 4'd1;
          if (s_axis.tlast) begin
            trunc_evt    = 1'b1;
            state_nxt    = IDLE;
            byte_cnt_nxt = 4'd0;
          end else if (byte_cnt == 4'd13) begin
            byte_cnt_nxt = 4'd0;
            if (match) begin
              hdr_evt   = 1'b1;
              state_nxt = PAYLOAD;
            end else begin
              drop_evt  = 1'b1;
              state_nxt = DROP;
            end
          end
        end
        PAYLOAD: begin
          beat_evt = 1'b1;
          if (s_axis.tlast) state_nxt = IDLE;
        end
        DROP: begin
          if (s_axis.tlast) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow         <= '0;
      hdr_q          <= '0;
      hdr_valid      <= 1'b0;
      m_tdata_q      <= '0;
      m_tvalid_q     <= 1'b0;
      m_tlast_q      <= 1'b0;
      m_tuser_q      <= 1'b0;
      stat_rx_frame  <= 1'b0;
      stat_rx_drop   <= 1'b0;
      stat_rx_trunc  <= 1'b0;
      stat_rx_error  <= 1'b0;
      count_rx_frame <= '0;
      count_rx_drop  <= '0;
    end else begin
      hdr_valid     <= hdr_evt;
      stat_rx_drop  <= drop_evt;
      stat_rx_trunc <= trunc_evt;
      m_tvalid_q    <= beat_evt;
      m_tlast_q     <= beat_evt & s_axis.tlast;
      m_tuser_q     <= beat_evt & s_axis.tlast & s_axis.tuser;
      stat_rx_frame <= beat_evt & s_axis.tlast;
      stat_rx_error <= beat_evt & s_axis.tlast & s_axis.tuser;
      if (shift_en) shadow    <= hdr_w[103:0];
      if (hdr_evt)  hdr_q     <= hdr_w;
      if (beat_evt) m_tdata_q <= s_axis.tdata;
      if (beat_evt & s_axis.tlast) count_rx_frame <= count_rx_frame + COUNT_WIDTH'(1);
      if (drop_evt)                count_rx_drop  <= count_rx_drop + COUNT_WIDTH'(1);
    end
  end

  assign hdr_dest_mac  = hdr_q.dest;
  assign hdr_src_mac   = hdr_q.src;
  assign hdr_type      = hdr_q.etype;
  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tvalid = m_tvalid_q;
  assign m_axis.tlast  = m_tlast_q;
  assign m_axis.tuser  = m_tuser_q;

endmodule

// File: tb/tb_eth_rx_hdr_filter.sv
// Randomized scoreboard bench for eth_rx_hdr_filter; expectations come from a frame-level model.
module tb_eth_rx_hdr_filter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hdr_valid;
  logic [47:0] hdr_dest_mac, hdr_src_mac;
  logic [15:0] hdr_type;
  logic [47:0] cfg_local_mac = 48'h02_00_00_00_00_01;
  logic        cfg_promisc = 1'b0, cfg_bcast_enable = 1'b0, cfg_mcast_enable = 1'b0;
  logic        stat_rx_frame, stat_rx_drop, stat_rx_trunc, stat_rx_error;
  logic [31:0] count_rx_frame, count_rx_drop;

  eth_rx_hdr_filter_if #(.DATA_WIDTH(8)) s_if ();
  eth_rx_hdr_filter_if #(.DATA_WIDTH(8)) m_if ();

  eth_rx_hdr_filter #(.DATA_WIDTH(8), .COUNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .s_axis(s_if), .m_axis(m_if),
    .hdr_valid(hdr_valid), .hdr_dest_mac(hdr_dest_mac), .hdr_src_mac(hdr_src_mac), .hdr_type(hdr_type),
    .cfg_local_mac(cfg_local_mac), .cfg_promisc(cfg_promisc),
    .cfg_bcast_enable(cfg_bcast_enable), .cfg_mcast_enable(cfg_mcast_enable),
    .stat_rx_frame(stat_rx_frame), .stat_rx_drop(stat_rx_drop),
    .stat_rx_trunc(stat_rx_trunc), .stat_rx_error(stat_rx_error),
    .count_rx_frame(count_rx_frame), .count_rx_drop(count_rx_drop)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [47:0] dst; logic [47:0] src; logic [15:0] typ; } hdr_exp_t;
  typedef struct { int cyc; logic [7:0] d; bit last; bit user; } beat_exp_t;
  typedef struct { int cyc; logic [3:0] vec; } stat_exp_t;   // {trunc, drop, error, frame}

  hdr_exp_t  hq[$];
  beat_exp_t bq[$];
  stat_exp_t sq[$];
  logic [7:0] frame_q[$];
  int cyc = 0;
  int checks = 0, errors = 0;
  int exp_frame = 0, exp_drop = 0;

  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic bit accept(input logic [47:0] d);
    return cfg_promisc || d == cfg_local_mac || (cfg_bcast_enable && d == BCAST) || (cfg_mcast_enable && d[40]);
  endfunction

  task automatic build(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t, input int len);
    logic [111:0] h;
    h = {d, s, t};
    frame_q.delete();
    for (int i = 0; i < len; i++) frame_q.push_back(i < 14 ? h[111-8*i -: 8] : 8'($urandom));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
    end
  endtask

  // gap: 0 = dense, 1 = one idle cycle before every byte, 2 = random idles.
  // stop_at >= 0 returns at the negedge where that byte would be driven.
  task automatic drive_frame(input bit err, input int gap, input int stop_at);
    int n;
    bit acc;
    logic [47:0] d;
    n = frame_q.size();
    acc = 1'b0;
    d = '0;
    if (n >= 6) d = {frame_q[0], frame_q[1], frame_q[2], frame_q[3], frame_q[4], frame_q[5]};
    for (int i = 0; i < n; i++) begin
      if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) idle(1);
      @(negedge clk);
      if (i == stop_at) return;
      s_if.tdata  = frame_q[i];
      s_if.tvalid = 1'b1;
      s_if.tlast  = (i == n - 1);
      s_if.tuser  = (i == n - 1) ? err : 1'($urandom);
      if (n <= 14) begin
        if (i == n - 1) sq.push_back('{cyc + 1, 4'b1000});
      end else begin
        if (i == 13) begin
          acc = accept(d);
          if (acc) hq.push_back('{cyc + 1, d, {frame_q[6], frame_q[7], frame_q[8], frame_q[9], frame_q[10], frame_q[11]}, {frame_q[12], frame_q[13]}});
          else     sq.push_back('{cyc + 1, 4'b0100});
        end
        if (i >= 14 && acc) bq.push_back('{cyc + 1, frame_q[i], i == n - 1, (i == n - 1) && err});
        if (i == n - 1 && acc) sq.push_back('{cyc + 1, err ? 4'b0011 : 4'b0001});
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (hdr_valid) begin
        if (hq.size() == 0) chk("hdr_unexpected", 1, 0);
        else begin
          hdr_exp_t h;
          h = hq.pop_front();
          chk("hdr_cycle", 64'(cyc), 64'(h.cyc));
          chk("hdr_dest", {16'h0, hdr_dest_mac}, {16'h0, h.dst});
          chk("hdr_src", {16'h0, hdr_src_mac}, {16'h0, h.src});
          chk("hdr_type", {48'h0, hdr_type}, {48'h0, h.typ});
        end
      end
      if (m_if.tvalid) begin
        if (bq.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          beat_exp_t b;
          b = bq.pop_front();
          chk("beat_cycle", 64'(cyc), 64'(b.cyc));
          chk("beat_data", {56'h0, m_if.tdata}, {56'h0, b.d});
          chk("beat_tlast", {63'h0, m_if.tlast}, {63'h0, b.last});
          chk("beat_tuser", {63'h0, m_if.tuser}, {63'h0, b.user});
        end
      end
      if (stat_rx_frame | stat_rx_drop | stat_rx_trunc | stat_rx_error) begin
        if (sq.size() == 0) chk("stat_unexpected", {60'h0, stat_rx_trunc, stat_rx_drop, stat_rx_error, stat_rx_frame}, 0);
        else begin
          stat_exp_t s;
          s = sq.pop_front();
          if (s.vec[0]) exp_frame++;
          if (s.vec[2]) exp_drop++;
          chk("stat_cycle", 64'(cyc), 64'(s.cyc));
          chk("stat_vec", {60'h0, stat_rx_trunc, stat_rx_drop, stat_rx_error, stat_rx_frame}, {60'h0, s.vec});
          chk("count_frame", {32'h0, count_rx_frame}, 64'(exp_frame));
          chk("count_drop", {32'h0, count_rx_drop}, 64'(exp_drop));
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hdr_valid"}, {63'h0, hdr_valid}, 0);
    chk({tag, "_hdr_dest"}, {16'h0, hdr_dest_mac}, 0);
    chk({tag, "_hdr_type"}, {48'h0, hdr_type}, 0);
    chk({tag, "_m_tvalid"}, {63'h0, m_if.tvalid}, 0);
    chk({tag, "_m_tdata"}, {56'h0, m_if.tdata}, 0);
    chk({tag, "_stats"}, {60'h0, stat_rx_trunc, stat_rx_drop, stat_rx_error, stat_rx_frame}, 0);
    chk({tag, "_count_frame"}, {32'h0, count_rx_frame}, 0);
    chk({tag, "_count_drop"}, {32'h0, count_rx_drop}, 0);
  endtask

  initial begin
    logic [47:0] rd;
    s_if.tdata = '0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Unicast to the station address, 64 bytes.
    build(cfg_local_mac, 48'h00_11_22_33_44_55, 16'h0800, 64);
    drive_frame(1'b0, 0, -1);
    idle(3);

    // Broadcast with the broadcast filter off, then on.
    build(BCAST, 48'h00_AA_BB_CC_DD_EE, 16'h0806, 30);
    drive_frame(1'b0, 0, -1);
    idle(2);
    cfg_bcast_enable = 1'b1;
    build(BCAST, 48'h00_AA_BB_CC_DD_EE, 16'h0806, 30);
    drive_frame(1'b0, 0, -1);
    idle(2);

    // Truncated frames: 10 bytes then exactly 14 bytes.
    build(cfg_local_mac, 48'h00_01_02_03_04_05, 16'h86DD, 10);
    drive_frame(1'b0, 0, -1);
    build(cfg_local_mac, 48'h00_01_02_03_04_05, 16'h86DD, 14);
    drive_frame(1'b0, 0, -1);
    idle(2);

    // MII pacing with a bad-frame flag on the last byte.
    build(cfg_local_mac, 48'h00_0A_0B_0C_0D_0E, 16'h0800, 25);
    drive_frame(1'b1, 1, -1);
    idle(2);

    // Back-to-back unicast then multicast; the minimum 15-byte frame is included.
    cfg_mcast_enable = 1'b1;
    build(cfg_local_mac, 48'h00_12_34_56_78_9A, 16'h0800, 15);
    drive_frame(1'b0, 0, -1);
    build(MCAST, 48'h00_BC_DE_F0_12_34, 16'h88CC, 40);
    drive_frame(1'b0, 0, -1);
    idle(3);

    for (int f = 0; f < 40; f++) begin
      cfg_promisc      = ($urandom_range(0, 5) == 0);
      cfg_bcast_enable = 1'($urandom);
      cfg_mcast_enable = 1'($urandom);
      case ($urandom_range(0, 3))
        0: rd = cfg_local_mac;
        1: rd = BCAST;
        2: rd = MCAST;
        default: rd = {8'($urandom) & 8'hFE, 8'($urandom), 32'($urandom)};
      endcase
      build(rd, {16'($urandom), 32'($urandom)}, 16'($urandom), $urandom_range(1, 40));
      drive_frame(1'($urandom), $urandom_range(0, 2), -1);
      idle($urandom_range(0, 2));
    end
    idle(3);

    // Reset at payload byte 20 of an accepted frame, then a clean frame.
    cfg_promisc = 1'b0; cfg_bcast_enable = 1'b0; cfg_mcast_enable = 1'b0;
    build(cfg_local_mac, 48'h00_55_66_77_88_99, 16'h0800, 60);
    drive_frame(1'b0, 0, 33);
    #2 rst_n = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    #1 chk_all_zero("midreset");
    hq.delete(); bq.delete(); sq.delete();
    exp_frame = 0;
    exp_drop  = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    build(cfg_local_mac, 48'h00_55_66_77_88_99, 16'h0800, 32);
    drive_frame(1'b0, 0, -1);
    idle(5);

    chk("hdr_left", 64'(hq.size()), 0);
    chk("beat_left", 64'(bq.size()), 0);
    chk("stat_left", 64'(sq.size()), 0);
    chk("final_count_frame", {32'h0, count_rx_frame}, 64'(exp_frame));
    chk("final_count_drop", {32'h0, count_rx_drop}, 64'(exp_drop));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
